// File: rtl/grid_pkg.sv
// Shared sizes, FSM state encoding and row type for the snake occupancy grid.
package grid_pkg;
  localparam int H_CELLS = 32;
  localparam int V_CELLS = 24;
  localparam int H_W     = 5;
  localparam int V_W     = 5;
  localparam int CNT_W   = 10;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_SWAP} state_e;
  typedef logic [H_CELLS-1:0] row_t;

  function automatic logic row_ok(input logic [V_W-1:0] y);
    return y < V_W'(V_CELLS);
  endfunction
endpackage

// File: rtl/grid_bank.sv
// V_CELLS x H_CELLS bit array: one-cycle clear, whole-array load, bit set with
// read-before-set hit, and a registered single-bit read port.
module grid_bank
  import grid_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clr,
  input  logic                              load_en,
  input  logic [V_CELLS-1:0][H_CELLS-1:0]   load_data,
  input  logic                              set_en,
  input  logic [H_W-1:0]                    set_x,
  input  logic [V_W-1:0]                    set_y,
  output logic                              set_hit,
  input  logic [H_W-1:0]                    rd_x,
  input  logic [V_W-1:0]                    rd_y,
  output logic                              rd_bit,
  output logic [V_CELLS-1:0][H_CELLS-1:0]   cells
);
  row_t set_row;

  assign set_row = row_ok(set_y) ? cells[set_y] : '0;
  assign set_hit = set_row[set_x];

  // clr beats load beats set, so a restart in the same cycle drops the write
  always_ff @(posedge clk) begin
    if (rst) begin
      cells  <= '0;
      rd_bit <= 1'b0;
    end else begin
      if (clr)
        cells <= '0;
      else if (load_en)
        cells <= load_data;
      else if (set_en && row_ok(set_y))
        cells[set_y][set_x] <= 1'b1;
      rd_bit <= row_ok(rd_y) && cells[rd_y][rd_x];
    end
  end
endmodule

// File: rtl/snake_grid_map.sv
// Builds a segment-occupancy bitmap in a back bank from a request/answer stream
// and swaps it into the front bank read by the pixel path on the tail segment.
module snake_grid_map
  import grid_pkg::*;
#(
  parameter int TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  output logic             seg_req,
  input  logic             seg_vld,
  input  logic [H_W-1:0]   seg_x,
  input  logic [V_W-1:0]   seg_y,
  input  logic             seg_last,
  input  logic [H_W-1:0]   rd_x,
  input  logic [V_W-1:0]   rd_y,
  output logic             rd_body,
  output logic             rd_head,
  output logic [H_W-1:0]   head_x,
  output logic [V_W-1:0]   head_y,
  output logic [CNT_W-1:0] seg_count,
  output logic             overlap,
  output logic             frame_done,
  output logic             frame_err
);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e                          state, nxt;
  logic [CNT_W-1:0]                wdog, b_cnt;
  logic                            b_ovl;
  logic [H_W-1:0]                  b_hx;
  logic [V_W-1:0]                  b_hy;
  logic                            back_clr, back_set, back_hit, front_load, err_nxt;
  logic                            head_hit;
  logic [V_CELLS-1:0][H_CELLS-1:0] back_cells;
  logic [V_CELLS-1:0][H_CELLS-1:0] unused_front_cells;
  logic                            unused_back_rd, unused_front_hit;

  assign seg_req    = (state == S_REQ);
  assign frame_done = (state == S_SWAP);
  assign rd_head    = head_hit & rd_body;

  always_comb begin
    nxt        = state;
    back_clr   = 1'b0;
    back_set   = 1'b0;
    front_load = 1'b0;
    err_nxt    = 1'b0;
    if (frame_start) begin
      back_clr = 1'b1;
      nxt      = S_REQ;
    end else begin
      case (state)
        S_REQ:  nxt = S_WAIT;
        S_WAIT: begin
          if (seg_vld) begin
            if (!row_ok(seg_y)) begin
              err_nxt = 1'b1;
              nxt     = S_IDLE;
            end else begin
              back_set = 1'b1;
              nxt      = seg_last ? S_SWAP : S_REQ;
            end
          end else if (wdog == WD_LAST) begin
            err_nxt = 1'b1;
            nxt     = S_IDLE;
          end
        end
        S_SWAP: begin
          front_load = 1'b1;
          nxt        = S_IDLE;
        end
        default: nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      wdog      <= '0;
      b_cnt     <= '0;
      b_ovl     <= 1'b0;
      b_hx      <= '0;
      b_hy      <= '0;
      head_x    <= '0;
      head_y    <= '0;
      seg_count <= '0;
      overlap   <= 1'b0;
      frame_err <= 1'b0;
      head_hit  <= 1'b0;
    end else begin
      state     <= nxt;
      frame_err <= err_nxt;
      head_hit  <= (rd_x == head_x) && (rd_y == head_y);
      if (state == S_REQ)
        wdog <= '0;
      else if (state == S_WAIT && !seg_vld)
        wdog <= wdog + 1'b1;
      if (back_clr) begin
        b_cnt <= '0;
        b_ovl <= 1'b0;
        b_hx  <= '0;
        b_hy  <= '0;
      end else if (back_set) begin
        if (b_cnt != CNT_MAX)
          b_cnt <= b_cnt + 1'b1;
        if (back_hit)
          b_ovl <= 1'b1;
        if (b_cnt == '0) begin
          b_hx <= seg_x;
          b_hy <= seg_y;
        end
      end
      if (front_load) begin
        head_x    <= b_hx;
        head_y    <= b_hy;
        seg_count <= b_cnt;
        overlap   <= b_ovl;
      end
    end
  end

  grid_bank u_back (
    .clk       (clk),
    .rst       (rst),
    .clr       (back_clr),
    .load_en   (1'b0),
    .load_data ('0),
    .set_en    (back_set),
    .set_x     (seg_x),
    .set_y     (seg_y),
    .set_hit   (back_hit),
    .rd_x      ('0),
    .rd_y      ('0),
    .rd_bit    (unused_back_rd),
    .cells     (back_cells)
  );

  grid_bank u_front (
    .clk       (clk),
    .rst       (rst),
    .clr       (1'b0),
    .load_en   (front_load),
    .load_data (back_cells),
    .set_en    (1'b0),
    .set_x     ('0),
    .set_y     ('0),
    .set_hit   (unused_front_hit),
    .rd_x      (rd_x),
    .rd_y      (rd_y),
    .rd_bit    (rd_body),
    .cells     (unused_front_cells)
  );
endmodule

// File: tb/tb_snake_grid_map.sv
// Directed bench for snake_grid_map: builds, overlap, timeout, bad row, restart.
module tb_snake_grid_map;
  logic       clk = 1'b0;
  logic       rst, frame_start, seg_vld, seg_last;
  logic [4:0] seg_x, seg_y, rd_x, rd_y, head_x, head_y;
  logic       seg_req, rd_body, rd_head, overlap, frame_done, frame_err;
  logic [9:0] seg_count;

  int n_tests = 0, n_fail = 0, cyc = 0;
  int n_done = 0, n_err = 0;

  snake_grid_map dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .seg_req(seg_req),
    .seg_vld(seg_vld), .seg_x(seg_x), .seg_y(seg_y), .seg_last(seg_last),
    .rd_x(rd_x), .rd_y(rd_y), .rd_body(rd_body), .rd_head(rd_head),
    .head_x(head_x), .head_y(head_y), .seg_count(seg_count), .overlap(overlap),
    .frame_done(frame_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (frame_done) n_done++;
    if (frame_err)  n_err++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input string tag);
    int k = 0;
    while (seg_req !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    chk(tag, 32'(seg_req), 1);
  endtask

  // answer the pending request one cycle later
  task automatic send_seg(input logic [4:0] x, input logic [4:0] y, input logic last);
    wait_req("seg_req");
    tick();
    seg_vld = 1'b1; seg_x = x; seg_y = y; seg_last = last;
    tick();
    seg_vld = 1'b0; seg_last = 1'b0;
  endtask

  task automatic start_frame(output int t0);
    frame_start = 1'b1;
    t0 = cyc;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic rd_cell(input logic [4:0] x, input logic [4:0] y, output logic b, output logic h);
    rd_x = x; rd_y = y;
    tick();
    b = rd_body; h = rd_head;
  endtask

  // occupied-cell count, sum of y*32+x over occupied cells, count of head hits
  task automatic scan(output int cnt, output int sum, output int hcnt);
    logic b, h;
    cnt = 0; sum = 0; hcnt = 0;
    for (int y = 0; y < 24; y++)
      for (int x = 0; x < 32; x++) begin
        rd_cell(5'(x), 5'(y), b, h);
        if (b) begin cnt++; sum += y * 32 + x; end
        if (h) hcnt++;
      end
  endtask

  initial begin
    int t0, r, k, cnt, sum, hcnt, d0, e0;
    logic b, h;
    rst = 1'b1; frame_start = 1'b0; seg_vld = 1'b0; seg_last = 1'b0;
    seg_x = '0; seg_y = '0; rd_x = '0; rd_y = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    chk("rst_head_x", 32'(head_x), 0);
    chk("rst_head_y", 32'(head_y), 0);
    chk("rst_seg_count", 32'(seg_count), 0);
    chk("rst_overlap", 32'(overlap), 0);
    chk("rst_seg_req", 32'(seg_req), 0);
    chk("rst_done_err", 32'({frame_done, frame_err}), 0);
    scan(cnt, sum, hcnt);
    chk("rst_body_cells", cnt, 0);
    chk("rst_head_cells", hcnt, 0);

    // frame A: (5,5) (4,5) (3,5 last)
    start_frame(t0);
    chk("a_req_latency", cyc - t0, 1);
    send_seg(5, 5, 0);
    send_seg(4, 5, 0);
    send_seg(3, 5, 1);
    chk("a_done_pulse", 32'(frame_done), 1);
    chk("a_done_latency", cyc - t0, 7);
    rd_cell(5, 5, b, h);
    chk("a_read_in_swap_old", 32'(b), 0);
    rd_cell(5, 5, b, h);
    chk("a_read_after_swap", 32'(b), 1);
    chk("a_head_at_55", 32'(h), 1);
    chk("a_seg_count", 32'(seg_count), 3);
    chk("a_overlap", 32'(overlap), 0);
    chk("a_head_xy", 32'({head_x, head_y}), 32'({5'd5, 5'd5}));
    scan(cnt, sum, hcnt);
    chk("a_cell_count", cnt, 3);
    chk("a_cell_sum", sum, 492);
    chk("a_head_count", hcnt, 1);
    rd_cell(4, 5, b, h);
    chk("a_no_head_45", 32'(h), 0);
    rd_cell(5, 24, b, h);
    chk("a_row24_read", 32'({b, h}), 0);

    // frame B: revisits (10,10)
    start_frame(t0);
    send_seg(10, 10, 0);
    send_seg(11, 10, 0);
    send_seg(11, 11, 0);
    send_seg(10, 11, 0);
    send_seg(10, 10, 1);
    chk("b_done_latency", cyc - t0, 11);
    tick();
    chk("b_seg_count", 32'(seg_count), 5);
    chk("b_overlap", 32'(overlap), 1);
    chk("b_head_xy", 32'({head_x, head_y}), 32'({5'd10, 5'd10}));
    scan(cnt, sum, hcnt);
    chk("b_cell_count", cnt, 4);
    chk("b_cell_sum", sum, 1386);

    // timeout after two segments
    d0 = n_done; e0 = n_err;
    start_frame(t0);
    send_seg(1, 1, 0);
    send_seg(2, 2, 0);
    wait_req("to_third_req");
    r = cyc;
    k = 0;
    while (frame_err !== 1'b1 && k < 1100) begin
      tick();
      k++;
    end
    chk("to_err_seen", 32'(frame_err), 1);
    chk("to_err_cycle", cyc - r, 1024);
    repeat (3) tick();
    chk("to_err_pulses", n_err - e0, 1);
    chk("to_no_done", n_done - d0, 0);
    chk("to_idle", 32'(seg_req), 0);
    chk("to_seg_count_kept", 32'(seg_count), 5);
    rd_cell(1, 1, b, h);
    chk("to_partial_absent", 32'(b), 0);
    rd_cell(11, 11, b, h);
    chk("to_front_kept", 32'(b), 1);

    // out-of-range row in WAIT
    e0 = n_err;
    start_frame(t0);
    wait_req("oor_req");
    tick();
    seg_vld = 1'b1; seg_x = 3; seg_y = 24; seg_last = 1'b0;
    tick();
    seg_vld = 1'b0;
    chk("oor_err", 32'(frame_err), 1);
    chk("oor_idle", 32'(seg_req), 0);
    repeat (3) tick();
    chk("oor_err_pulses", n_err - e0, 1);
    chk("oor_still_idle", 32'({seg_req, frame_done}), 0);
    chk("oor_front_kept", 32'(seg_count), 5);

    // restart colliding with a segment
    start_frame(t0);
    send_seg(1, 2, 0);
    wait_req("rs_req");
    tick();
    seg_vld = 1'b1; seg_x = 7; seg_y = 7; seg_last = 1'b0; frame_start = 1'b1;
    tick();
    seg_vld = 1'b0; frame_start = 1'b0;
    chk("rs_req_next", 32'(seg_req), 1);
    send_seg(20, 3, 0);
    send_seg(21, 3, 1);
    chk("rs_done", 32'(frame_done), 1);
    tick();
    chk("rs_seg_count", 32'(seg_count), 2);
    chk("rs_overlap", 32'(overlap), 0);
    chk("rs_head_xy", 32'({head_x, head_y}), 32'({5'd20, 5'd3}));
    scan(cnt, sum, hcnt);
    chk("rs_cell_count", cnt, 2);
    chk("rs_cell_sum", sum, 233);
    rd_cell(7, 7, b, h);
    chk("rs_77_absent", 32'(b), 0);
    rd_cell(20, 3, b, h);
    chk("rs_head_cell", 32'({b, h}), 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
